// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/clear sequencer for a four-digit BCD stopwatch (SS.hh).
// Optional lap display freeze is built when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 500000
) (
  input  logic       CLOCK_50,
  input  logic       RST_N,
  input  logic       START,
  input  logic       STOP,
  input  logic       CLEAR,
  input  logic       LAP,
  output logic [3:0] DIGIT0,
  output logic [3:0] DIGIT1,
  output logic [3:0] DIGIT2,
  output logic [3:0] DIGIT3,
  output logic       RUNNING,
  output logic       TICK,
  output logic       WRAP,
  output logic       HOLD
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;
  state_t      r_state;
  logic [25:0] r_pre;
  logic [15:0] r_cnt;
  logic [15:0] w_inc;
  logic [15:0] w_disp;
  logic        r_running;
  logic        r_tick;
  logic        r_wrap;
  logic        w_pre_wrap;
  logic        w_step;
  logic        w_max;
  assign w_pre_wrap = r_pre == 26'(TICK_DIV - 1);
  assign w_step     = (r_state == S_RUN) && w_pre_wrap && !CLEAR;
  assign w_max      = r_cnt == 16'h9999;
  // cascaded decimal increment: a digit advances only when every lower digit is 9
  always_comb begin
    logic c;
    c = 1'b1;
    w_inc = r_cnt;
    for (int i = 0; i < 4; i++) begin
      w_inc[4*i +: 4] = c ? ((r_cnt[4*i +: 4] == 4'd9) ? 4'd0 : r_cnt[4*i +: 4] + 4'd1) : r_cnt[4*i +: 4];
      c = c && (r_cnt[4*i +: 4] == 4'd9);
    end
  end
  // control FSM with prescaler, count and registered status flags; CLEAR beats everything
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_pre     <= '0;
      r_cnt     <= '0;
      r_running <= 1'b0;
      r_tick    <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_tick <= w_step;
      r_wrap <= w_step && w_max;
      if (CLEAR) begin
        r_state   <= S_IDLE;
        r_pre     <= '0;
        r_cnt     <= '0;
        r_running <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_pre <= w_pre_wrap ? '0 : r_pre + 26'd1;
        if (w_pre_wrap) r_cnt <= w_inc;
        if (STOP) begin
          r_state   <= S_PAUSE;
          r_running <= 1'b0;
        end
      end else if (START) begin
        r_state   <= S_RUN;
        r_running <= 1'b1;
      end
    end
  end
`ifdef STOPWATCH_LAP_EN
  logic        r_hold;
  logic [15:0] r_snap;
  // lap freeze: snapshot the pre-update count when HOLD is set, live count once released
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      r_hold <= 1'b0;
      r_snap <= '0;
    end else if (CLEAR) begin
      r_hold <= 1'b0;
    end else if (LAP && r_state != S_IDLE) begin
      r_hold <= !r_hold;
      if (!r_hold) r_snap <= r_cnt;
    end
  end
  assign w_disp = r_hold ? r_snap : r_cnt;
  assign HOLD   = r_hold;
`else
  logic w_unused_lap;
  assign w_unused_lap = LAP;
  assign w_disp       = r_cnt;
  assign HOLD         = 1'b0;
`endif
  assign DIGIT0  = w_disp[3:0];
  assign DIGIT1  = w_disp[7:4];
  assign DIGIT2  = w_disp[11:8];
  assign DIGIT3  = w_disp[15:12];
  assign RUNNING = r_running;
  assign TICK    = r_tick;
  assign WRAP    = r_wrap;
endmodule
